// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter between the fetch and memory stages.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ_DM  = 3'd1,
        S_RESP_DM = 3'd2,
        S_REQ_IF  = 3'd3,
        S_RESP_IF = 3'd4
    } arb_state_t;

    localparam int PERF_W           = 32;
    localparam int DEF_MAX_DM_BURST = 4;

    // The counter must be able to hold the value max_burst itself, because it saturates there.
    function automatic int burst_cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    localparam int BURST_CNT_W = burst_cnt_w(DEF_MAX_DM_BURST);

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-ported memory bus between the arbiter (master) and the unified I/D memory (slave).
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [DW/8-1:0]   mem_be_o;
    logic [AW-1:0]     mem_addr_o;
    logic [DW-1:0]     mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DW-1:0]     mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_port_arbiter_instr_buffer.sv
// One-entry fetched-instruction buffer; flush beats load beats consume.
module instr_buffer #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_consume,
    input  logic          i_flush,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data,
    output logic          o_valid
);
    logic [DW-1:0] r_data;
    logic          r_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            // A word landing while the old one is consumed simply replaces it.
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between fetch (IF) and data (M) accesses and drives pipeline enables.
// Optional feature macro: MEM_ARB_PERF_CNT_EN enables the two 32-bit stall performance counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_DM_BURST  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic                      if_req_i,
    input  logic [ADDRESS_WIDTH-1:0]  if_addr_i,
    output logic [DATA_WIDTH-1:0]     if_rdata_o,
    output logic                      if_valid_o,
    output logic                      fen_o,
    input  logic                      dm_req_i,
    input  logic                      dm_we_i,
    input  logic [DATA_WIDTH/8-1:0]   dm_be_i,
    input  logic [ADDRESS_WIDTH-1:0]  dm_addr_i,
    input  logic [DATA_WIDTH-1:0]     dm_wdata_i,
    output logic [DATA_WIDTH-1:0]     dm_rdata_o,
    output logic                      dm_valid_o,
    output logic                      pipe_en_o,
    mem_port_arbiter_if.master        mem_bus,
    output logic [PERF_W-1:0]         perf_dm_stall_o,
    output logic [PERF_W-1:0]         perf_if_stall_o
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = burst_cnt_w(MAX_DM_BURST);

    arb_state_t               r_state;
    logic [CNT_W-1:0]         r_burst_cnt;
    logic                     r_drop;
    logic                     r_dm_valid;
    logic [DATA_WIDTH-1:0]    r_dm_rdata;
    logic                     r_mem_req;
    logic                     r_mem_we;
    logic [BE_W-1:0]          r_mem_be;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0]    r_mem_wdata;

    logic                     w_if_valid;
    logic [DATA_WIDTH-1:0]    w_if_rdata;
    logic                     w_pipe_en;
    logic                     w_fen;
    logic                     w_fetch_elig;
    logic                     w_dm_pending;
    logic                     w_burst_full;
    logic                     w_buf_load;

    assign w_pipe_en    = !dm_req_i || r_dm_valid;
    assign w_fen        = w_if_valid && w_pipe_en;
    assign w_fetch_elig = if_req_i && !w_if_valid && !flush_i;
    assign w_dm_pending = dm_req_i && !r_dm_valid;
    assign w_burst_full = (r_burst_cnt == CNT_W'(MAX_DM_BURST));
    // A flush arriving in the same cycle as the response must also discard it.
    assign w_buf_load   = (r_state == S_RESP_IF) && mem_bus.mem_rvalid_i && !r_drop && !flush_i;

    instr_buffer #(.DW(DATA_WIDTH)) u_instr_buffer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_buf_load),
        .i_consume (w_fen),
        .i_flush   (flush_i),
        .i_data    (mem_bus.mem_rdata_i),
        .o_data    (w_if_rdata),
        .o_valid   (w_if_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_burst_cnt <= '0;
            r_drop      <= 1'b0;
            r_dm_valid  <= 1'b0;
            r_dm_rdata  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_dm_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Data wins unless it has used up its burst allowance while fetch is waiting.
                    if (w_dm_pending && !(w_burst_full && w_fetch_elig)) begin
                        r_state     <= S_REQ_DM;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= dm_we_i;
                        r_mem_be    <= dm_we_i ? dm_be_i : '1;
                        r_mem_addr  <= dm_addr_i;
                        r_mem_wdata <= dm_we_i ? dm_wdata_i : '0;
                    end else if (w_fetch_elig) begin
                        r_state     <= S_REQ_IF;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_be    <= '1;
                        r_mem_addr  <= if_addr_i;
                        r_mem_wdata <= '0;
                    end
                end
                S_REQ_DM: begin
                    if (mem_bus.mem_gnt_i) begin
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_be    <= '0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        if (if_req_i && !w_burst_full) begin
                            r_burst_cnt <= r_burst_cnt + 1'b1;
                        end
                        if (r_mem_we) begin
                            r_state    <= S_IDLE;
                            r_dm_valid <= 1'b1;
                        end else begin
                            r_state <= S_RESP_DM;
                        end
                    end
                end
                S_RESP_DM: begin
                    if (mem_bus.mem_rvalid_i) begin
                        r_dm_rdata <= mem_bus.mem_rdata_i;
                        r_dm_valid <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                S_REQ_IF: begin
                    if (flush_i) begin
                        r_drop <= 1'b1;
                    end
                    if (mem_bus.mem_gnt_i) begin
                        r_mem_req   <= 1'b0;
                        r_mem_be    <= '0;
                        r_mem_addr  <= '0;
                        r_burst_cnt <= '0;
                        r_state     <= S_RESP_IF;
                    end
                end
                S_RESP_IF: begin
                    if (flush_i) begin
                        r_drop <= 1'b1;
                    end
                    if (mem_bus.mem_rvalid_i) begin
                        r_drop  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign if_rdata_o          = w_if_rdata;
    assign if_valid_o          = w_if_valid;
    assign fen_o               = w_fen;
    assign pipe_en_o           = w_pipe_en;
    assign dm_rdata_o          = r_dm_rdata;
    assign dm_valid_o          = r_dm_valid;
    assign mem_bus.mem_req_o   = r_mem_req;
    assign mem_bus.mem_we_o    = r_mem_we;
    assign mem_bus.mem_be_o    = r_mem_be;
    assign mem_bus.mem_addr_o  = r_mem_addr;
    assign mem_bus.mem_wdata_o = r_mem_wdata;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [PERF_W-1:0] r_perf_dm_stall;
    logic [PERF_W-1:0] r_perf_if_stall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_dm_stall <= '0;
            r_perf_if_stall <= '0;
        end else begin
            if (!w_pipe_en) begin
                r_perf_dm_stall <= r_perf_dm_stall + 1'b1;
            end
            if (!w_if_valid && if_req_i) begin
                r_perf_if_stall <= r_perf_if_stall + 1'b1;
            end
        end
    end

    assign perf_dm_stall_o = r_perf_dm_stall;
    assign perf_if_stall_o = r_perf_if_stall;
`else
    assign perf_dm_stall_o = '0;
    assign perf_if_stall_o = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, load, store, burst limit, flush and reset-abort scenarios.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_valid_o;
    logic        fen_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [3:0]  dm_be_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_valid_o;
    logic        pipe_en_o;
    logic [31:0] perf_dm_stall_o;
    logic [31:0] perf_if_stall_o;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter_if #(.AW(32), .DW(32)) mem_if ();

    mem_port_arbiter #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .MAX_DM_BURST  (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .if_req_i        (if_req_i),
        .if_addr_i       (if_addr_i),
        .if_rdata_o      (if_rdata_o),
        .if_valid_o      (if_valid_o),
        .fen_o           (fen_o),
        .dm_req_i        (dm_req_i),
        .dm_we_i         (dm_we_i),
        .dm_be_i         (dm_be_i),
        .dm_addr_i       (dm_addr_i),
        .dm_wdata_i      (dm_wdata_i),
        .dm_rdata_o      (dm_rdata_o),
        .dm_valid_o      (dm_valid_o),
        .pipe_en_o       (pipe_en_o),
        .mem_bus         (mem_if.master),
        .perf_dm_stall_o (perf_dm_stall_o),
        .perf_if_stall_o (perf_if_stall_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; flush_i = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h0000_0040;
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'hF; dm_addr_i = 32'h0000_0300; dm_wdata_i = 32'h1111_2222;
        mem_if.mem_gnt_i = 1'b1; mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 32'h5555_AAAA;

        // Reset with busy inputs: every registered output must read zero.
        tick(); tick();
        check("rst_mem_req", {31'd0, mem_if.mem_req_o}, 32'd0);
        check("rst_mem_addr", mem_if.mem_addr_o, 32'd0);
        check("rst_mem_be", {28'd0, mem_if.mem_be_o}, 32'd0);
        check("rst_dm_valid", {31'd0, dm_valid_o}, 32'd0);
        check("rst_dm_rdata", dm_rdata_o, 32'd0);
        check("rst_if_valid", {31'd0, if_valid_o}, 32'd0);
        check("rst_perf_dm", perf_dm_stall_o, 32'd0);
        check("rst_perf_if", perf_if_stall_o, 32'd0);
        $display("txn reset done");

        // 1: fetch only, gnt one cycle late, rvalid two cycles after gnt.
        dm_req_i = 1'b0; mem_if.mem_gnt_i = 1'b0; mem_if.mem_rvalid_i = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h0; rst = 1'b1;
        tick();
        check("t1_req", {31'd0, mem_if.mem_req_o}, 32'd1);
        check("t1_addr", mem_if.mem_addr_o, 32'h0);
        check("t1_be", {28'd0, mem_if.mem_be_o}, 32'hF);
        check("t1_we", {31'd0, mem_if.mem_we_o}, 32'd0);
        tick();
        check("t1_req_hold", {31'd0, mem_if.mem_req_o}, 32'd1);
        mem_if.mem_gnt_i = 1'b1; tick(); mem_if.mem_gnt_i = 1'b0;
        check("t1_req_drop", {31'd0, mem_if.mem_req_o}, 32'd0);
        tick();
        mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 32'h0050_0093;
        tick(); mem_if.mem_rvalid_i = 1'b0;
        check("t1_if_valid", {31'd0, if_valid_o}, 32'd1);
        check("t1_if_rdata", if_rdata_o, 32'h0050_0093);
        check("t1_fen", {31'd0, fen_o}, 32'd1);
        if_req_i = 1'b0;
        tick();
        check("t1_consumed", {31'd0, if_valid_o}, 32'd0);
        $display("txn fetch addr=0x00000000 data=0x%08h", if_rdata_o);

        // 2: simultaneous load and fetch; data goes first.
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h100; if_req_i = 1'b1; if_addr_i = 32'h4;
        #1;
        check("t2_pipe_stall0", {31'd0, pipe_en_o}, 32'd0);
        tick();
        check("t2_dm_first_addr", mem_if.mem_addr_o, 32'h100);
        check("t2_dm_first_we", {31'd0, mem_if.mem_we_o}, 32'd0);
        check("t2_dm_load_be", {28'd0, mem_if.mem_be_o}, 32'hF);
        mem_if.mem_gnt_i = 1'b1; tick(); mem_if.mem_gnt_i = 1'b0;
        check("t2_pipe_stall1", {31'd0, pipe_en_o}, 32'd0);
        check("t2_no_valid_yet", {31'd0, dm_valid_o}, 32'd0);
        mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 32'h1234_5678;
        tick(); mem_if.mem_rvalid_i = 1'b0;
        check("t2_dm_valid", {31'd0, dm_valid_o}, 32'd1);
        check("t2_dm_rdata", dm_rdata_o, 32'h1234_5678);
        check("t2_pipe_en", {31'd0, pipe_en_o}, 32'd1);
        dm_req_i = 1'b0;
        tick();
        check("t2_valid_pulse", {31'd0, dm_valid_o}, 32'd0);
        check("t2_fetch_req", {31'd0, mem_if.mem_req_o}, 32'd1);
        check("t2_fetch_addr", mem_if.mem_addr_o, 32'h4);
        mem_if.mem_gnt_i = 1'b1; tick(); mem_if.mem_gnt_i = 1'b0;
        mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 32'hAAAA_0001;
        tick(); mem_if.mem_rvalid_i = 1'b0;
        check("t2_if_rdata", if_rdata_o, 32'hAAAA_0001);
        if_req_i = 1'b0;
        tick();
        $display("txn load addr=0x00000100 data=0x12345678 then fetch addr=0x00000004");

        // 3: partial store, request held until gnt, completion one cycle after gnt.
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'b0011; dm_addr_i = 32'h200; dm_wdata_i = 32'hDEAD_BEEF;
        tick();
        check("t3_we", {31'd0, mem_if.mem_we_o}, 32'd1);
        check("t3_be", {28'd0, mem_if.mem_be_o}, 32'h3);
        check("t3_wdata", mem_if.mem_wdata_o, 32'hDEAD_BEEF);
        tick();
        check("t3_hold_req", {31'd0, mem_if.mem_req_o}, 32'd1);
        check("t3_hold_be", {28'd0, mem_if.mem_be_o}, 32'h3);
        mem_if.mem_gnt_i = 1'b1; tick(); mem_if.mem_gnt_i = 1'b0;
        check("t3_dm_valid", {31'd0, dm_valid_o}, 32'd1);
        check("t3_req_drop", {31'd0, mem_if.mem_req_o}, 32'd0);
        dm_req_i = 1'b0;
        tick();
        check("t3_valid_pulse", {31'd0, dm_valid_o}, 32'd0);
        check("t3_no_reissue", {31'd0, mem_if.mem_req_o}, 32'd0);
        $display("txn store addr=0x00000200 be=0011 data=0xdeadbeef");

        // 4: four back-to-back stores while fetch is pending (held off by flush), then fetch wins.
        if_req_i = 1'b1; if_addr_i = 32'h40; flush_i = 1'b1;
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'hF; dm_addr_i = 32'h300;
        for (int k = 0; k < 4; k++) begin
            dm_wdata_i = 32'h100 + k;
            tick();
            check($sformatf("t4_dm_req%0d", k), {31'd0, mem_if.mem_we_o}, 32'd1);
            mem_if.mem_gnt_i = 1'b1; tick(); mem_if.mem_gnt_i = 1'b0;
            check($sformatf("t4_dm_valid%0d", k), {31'd0, dm_valid_o}, 32'd1);
            tick();
            check($sformatf("t4_idle%0d", k), {31'd0, mem_if.mem_req_o}, 32'd0);
            $display("txn burst store %0d addr=0x00000300", k);
        end
        flush_i = 1'b0;
        tick();
        check("t4_fetch_wins_req", {31'd0, mem_if.mem_req_o}, 32'd1);
        check("t4_fetch_wins_addr", mem_if.mem_addr_o, 32'h40);
        check("t4_fetch_wins_we", {31'd0, mem_if.mem_we_o}, 32'd0);
        mem_if.mem_gnt_i = 1'b1; tick(); mem_if.mem_gnt_i = 1'b0;
        mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 32'hBBBB_0002;
        tick(); mem_if.mem_rvalid_i = 1'b0;
        check("t4_buf_valid", {31'd0, if_valid_o}, 32'd1);
        check("t4_fen_stalled", {31'd0, fen_o}, 32'd0);
        tick();
        check("t4_dm_after_fetch", mem_if.mem_addr_o, 32'h300);
        check("t4_dm_after_fetch_we", {31'd0, mem_if.mem_we_o}, 32'd1);
        mem_if.mem_gnt_i = 1'b1; tick(); mem_if.mem_gnt_i = 1'b0;
        check("t4_fen_release", {31'd0, fen_o}, 32'd1);
        dm_req_i = 1'b0; if_req_i = 1'b0;
        tick();
        check("t4_buf_consumed", {31'd0, if_valid_o}, 32'd0);
        $display("txn fetch addr=0x00000040 after burst limit");

        // 5: flush while the fetch response is outstanding; next fetch uses the redirected PC.
        if_req_i = 1'b1; if_addr_i = 32'h80;
        tick();
        check("t5_fetch_addr", mem_if.mem_addr_o, 32'h80);
        mem_if.mem_gnt_i = 1'b1; tick(); mem_if.mem_gnt_i = 1'b0;
        flush_i = 1'b1; if_addr_i = 32'h200;
        tick(); flush_i = 1'b0;
        check("t5_wait_resp", {31'd0, mem_if.mem_req_o}, 32'd0);
        mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 32'hCCCC_0003;
        tick(); mem_if.mem_rvalid_i = 1'b0;
        check("t5_dropped", {31'd0, if_valid_o}, 32'd0);
        tick();
        check("t5_refetch_req", {31'd0, mem_if.mem_req_o}, 32'd1);
        check("t5_refetch_addr", mem_if.mem_addr_o, 32'h200);
        mem_if.mem_gnt_i = 1'b1; tick(); mem_if.mem_gnt_i = 1'b0;
        mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 32'hDDDD_0004;
        tick(); mem_if.mem_rvalid_i = 1'b0;
        check("t5_refetch_valid", {31'd0, if_valid_o}, 32'd1);
        check("t5_refetch_data", if_rdata_o, 32'hDDDD_0004);
        if_req_i = 1'b0;
        tick();
        $display("txn flushed fetch addr=0x00000080 refetch addr=0x00000200");

        // 6: reset asserted while a load waits for its response; the late response is ignored.
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h100;
        tick();
        mem_if.mem_gnt_i = 1'b1; tick(); mem_if.mem_gnt_i = 1'b0;
        rst = 1'b0;
        tick();
        check("t6_rst_req", {31'd0, mem_if.mem_req_o}, 32'd0);
        check("t6_rst_valid", {31'd0, dm_valid_o}, 32'd0);
        rst = 1'b1; dm_req_i = 1'b0;
        mem_if.mem_rvalid_i = 1'b1; mem_if.mem_rdata_i = 32'h0000_0099;
        tick(); mem_if.mem_rvalid_i = 1'b0;
        check("t6_late_valid", {31'd0, dm_valid_o}, 32'd0);
        check("t6_late_rdata", dm_rdata_o, 32'd0);
        check("t6_late_if_valid", {31'd0, if_valid_o}, 32'd0);
        if_req_i = 1'b1; if_addr_i = 32'h10;
        tick();
        check("t6_idle_fetch", mem_if.mem_addr_o, 32'h10);
        check("t6_idle_fetch_req", {31'd0, mem_if.mem_req_o}, 32'd1);
        $display("txn reset during load, late rvalid ignored");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
